history_bank: RTL and testbench

- Downstream of the per-bank literal/copy selector stage.
- Consumes its registered output stream (64-bit data, 9-bit line address, 8-bit byte-valid, valid) and writes it into one 512x64 history-buffer bank with byte enables.
- Keeps a per-byte "written" bitmap, so copy-read requests know whether the bytes they need have been produced yet.
- Serves one read port with write-to-read forwarding, returning data plus a hit flag to the copy/read-request stage.

---
 rtl/history_bank_pkg.sv | 20 ++
 rtl/history_bank_ram.sv | 36 +++
 rtl/history_bank.sv | 125 ++++++++++++
 tb/tb_history_bank.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/history_bank_pkg.sv
// history_bank_pkg: shared widths and byte-mask helpers for the history-buffer bank.
package history_bank_pkg;

  localparam int unsigned BANK_ADDR_W = 9;
  localparam int unsigned BANK_BYTES  = 8;
  localparam int unsigned BANK_DATA_W = 8 * BANK_BYTES;

  typedef logic [BANK_BYTES-1:0] byte_mask_t;

  // True when every byte asked for in need is present in have.
  function automatic logic mask_covered(byte_mask_t have, byte_mask_t need);
    return (have & need) == need;
  endfunction

  // True when a line's written-bitmap has every byte set.
  function automatic logic mask_full(byte_mask_t m);
    return &m;
  endfunction

endpackage

// File: rtl/history_bank_ram.sv
// history_bank_ram: simple dual-port RAM, byte-enabled write port and a registered read port.
// Ports:
//   clk      - clock
//   wr_en    - write strobe; wr_addr/wr_data/wr_be qualify it
//   rd_en    - read strobe; rd_data is mem[rd_addr] one cycle later
// A read colliding with a write returns the pre-write contents.
module history_bank_ram
  import history_bank_pkg::*;
#(
  parameter int unsigned ADDR_W    = BANK_ADDR_W,
  parameter int unsigned NUM_BYTES = BANK_BYTES
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [8*NUM_BYTES-1:0] wr_data,
  input  logic [NUM_BYTES-1:0]   wr_be,
  input  logic                   rd_en,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [8*NUM_BYTES-1:0] rd_data
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [8*NUM_BYTES-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/history_bank.sv
// history_bank: one 512x64 history-buffer bank with per-byte written bitmap.
// Ports:
//   clk, rst_n                  - clock, async active-low reset
//   wr_valid/wr_address/wr_data/wr_byte_valid - byte-enabled line write
//   rd_req/rd_address/rd_byte_mask            - read request, bytes the requester needs
//   clr_valid/clr_address       - clear one line's written bitmap
//   rd_data_out/rd_valid_out/rd_hit_out       - read result, one cycle after rd_req
//   wr_count_out                - number of lines whose bitmap is all ones
module history_bank
  import history_bank_pkg::*;
#(
  parameter int unsigned ADDR_W    = BANK_ADDR_W,
  parameter int unsigned NUM_BYTES = BANK_BYTES,
  parameter bit          FWD_EN    = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_valid,
  input  logic [ADDR_W-1:0]      wr_address,
  input  logic [8*NUM_BYTES-1:0] wr_data,
  input  logic [NUM_BYTES-1:0]   wr_byte_valid,
  input  logic                   rd_req,
  input  logic [ADDR_W-1:0]      rd_address,
  input  logic [NUM_BYTES-1:0]   rd_byte_mask,
  input  logic                   clr_valid,
  input  logic [ADDR_W-1:0]      clr_address,
  output logic [8*NUM_BYTES-1:0] rd_data_out,
  output logic                   rd_valid_out,
  output logic                   rd_hit_out,
  output logic [ADDR_W:0]        wr_count_out
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [NUM_BYTES-1:0]   bitmap_q [Depth];
  logic                   rd_valid_q, rd_hit_q, rd_hit_d;
  logic [NUM_BYTES-1:0]   fwd_be_q, fwd_be_d;
  logic [8*NUM_BYTES-1:0] fwd_data_q;
  logic [ADDR_W:0]        count_q, count_d;
  logic [8*NUM_BYTES-1:0] ram_rd_data;

  logic                   same_wc, fwd_hit, w_up, w_down, c_down;
  logic [NUM_BYTES-1:0]   wr_line_old, wr_line_new, rd_line_eff;

  history_bank_ram #(
    .ADDR_W   (ADDR_W),
    .NUM_BYTES(NUM_BYTES)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_valid),
    .wr_addr(wr_address),
    .wr_data(wr_data),
    .wr_be  (wr_byte_valid),
    .rd_en  (rd_req),
    .rd_addr(rd_address),
    .rd_data(ram_rd_data)
  );

  always_comb begin
    same_wc     = clr_valid && wr_valid && (clr_address == wr_address);
    wr_line_old = bitmap_q[wr_address];
    // Clear takes effect before the write OR on a shared line.
    wr_line_new = (same_wc ? '0 : wr_line_old) | wr_byte_valid;

    // At most one up and one down event per cycle: w_down needs a shared line, c_down a distinct one.
    w_up   = wr_valid && !mask_full(wr_line_old) && mask_full(wr_line_new);
    w_down = same_wc && mask_full(wr_line_old) && !mask_full(wr_line_new);
    c_down = clr_valid && !same_wc && mask_full(bitmap_q[clr_address]);

    count_d = count_q;
    if (w_up && !(w_down || c_down)) begin
      count_d = count_q + (ADDR_W+1)'(1);
    end else if (!w_up && (w_down || c_down)) begin
      count_d = count_q - (ADDR_W+1)'(1);
    end

    fwd_hit     = FWD_EN && wr_valid && rd_req && (wr_address == rd_address);
    rd_line_eff = bitmap_q[rd_address];
    if (clr_valid && (clr_address == rd_address)) rd_line_eff = '0;
    if (fwd_hit) rd_line_eff = rd_line_eff | wr_byte_valid;
    rd_hit_d = mask_covered(rd_line_eff, rd_byte_mask);
    fwd_be_d = fwd_hit ? wr_byte_valid : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) bitmap_q[i] <= '0;
    end else begin
      if (clr_valid) bitmap_q[clr_address] <= '0;
      // Later assignment wins when clear and write hit the same line.
      if (wr_valid) bitmap_q[wr_address] <= wr_line_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_hit_q   <= 1'b0;
      fwd_be_q   <= '0;
      fwd_data_q <= '0;
      count_q    <= '0;
    end else begin
      rd_valid_q <= rd_req;
      rd_hit_q   <= rd_req && rd_hit_d;
      fwd_be_q   <= fwd_be_d;
      fwd_data_q <= wr_data;
      count_q    <= count_d;
    end
  end

  // RAM output register has no reset, so gate the data with the valid flop.
  always_comb begin
    rd_data_out = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (rd_valid_q) begin
        rd_data_out[8*i +: 8] = fwd_be_q[i] ? fwd_data_q[8*i +: 8] : ram_rd_data[8*i +: 8];
      end
    end
  end

  assign rd_valid_out = rd_valid_q;
  assign rd_hit_out   = rd_hit_q;
  assign wr_count_out = count_q;

endmodule

// File: tb/tb_history_bank.sv
module tb_history_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic [8:0]  wr_address;
  logic [63:0] wr_data;
  logic [7:0]  wr_byte_valid;
  logic        rd_req;
  logic [8:0]  rd_address;
  logic [7:0]  rd_byte_mask;
  logic        clr_valid;
  logic [8:0]  clr_address;

  logic [63:0] rd_data_out, rd_data_nf;
  logic        rd_valid_out, rd_valid_nf;
  logic        rd_hit_out, rd_hit_nf;
  logic [9:0]  wr_count_out, wr_count_nf;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: memory, bytes ever written (memory survives reset), written bitmap.
  logic [63:0] mem_m   [512];
  logic [7:0]  known_m [512];
  logic [7:0]  bm_m    [512];

  always #5 clk = ~clk;

  history_bank #(.FWD_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_address(wr_address), .wr_data(wr_data),
    .wr_byte_valid(wr_byte_valid),
    .rd_req(rd_req), .rd_address(rd_address), .rd_byte_mask(rd_byte_mask),
    .clr_valid(clr_valid), .clr_address(clr_address),
    .rd_data_out(rd_data_out), .rd_valid_out(rd_valid_out), .rd_hit_out(rd_hit_out),
    .wr_count_out(wr_count_out)
  );

  history_bank #(.FWD_EN(1'b0)) dut_nf (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_address(wr_address), .wr_data(wr_data),
    .wr_byte_valid(wr_byte_valid),
    .rd_req(rd_req), .rd_address(rd_address), .rd_byte_mask(rd_byte_mask),
    .clr_valid(clr_valid), .clr_address(clr_address),
    .rd_data_out(rd_data_nf), .rd_valid_out(rd_valid_nf), .rd_hit_out(rd_hit_nf),
    .wr_count_out(wr_count_nf)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] expand(input logic [7:0] m);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = {8{m[i]}};
    return r;
  endfunction

  function automatic int full_lines();
    int n = 0;
    for (int i = 0; i < 512; i++) if (bm_m[i] == 8'hFF) n++;
    return n;
  endfunction

  // One clock: predict from the rules, advance the model, then compare both DUTs.
  task automatic cycle();
    logic        req;
    logic [7:0]  nf_bm, nf_known, f_bm, f_known, mask;
    logic [63:0] nf_data, f_data;
    int          cnt;
    req  = rd_req;
    mask = rd_byte_mask;
    // Without forwarding: state after the clear but before the write.
    nf_bm = bm_m[rd_address];
    if (clr_valid && clr_address == rd_address) nf_bm = 8'h00;
    nf_data  = mem_m[rd_address];
    nf_known = known_m[rd_address];
    if (clr_valid) bm_m[clr_address] = 8'h00;
    if (wr_valid) begin
      for (int i = 0; i < 8; i++) begin
        if (wr_byte_valid[i]) mem_m[wr_address][8*i +: 8] = wr_data[8*i +: 8];
      end
      known_m[wr_address] = known_m[wr_address] | wr_byte_valid;
      bm_m[wr_address]    = bm_m[wr_address] | wr_byte_valid;
    end
    // With forwarding the read sees the line as it stands after this edge.
    f_bm    = bm_m[rd_address];
    f_data  = mem_m[rd_address];
    f_known = known_m[rd_address];
    cnt     = full_lines();
    @(posedge clk);
    #1;
    chk("rd_valid", 64'(rd_valid_out), 64'(req));
    chk("wr_count", 64'(wr_count_out), 64'(cnt));
    chk("nf_wr_count", 64'(wr_count_nf), 64'(cnt));
    if (req) begin
      chk("rd_hit", 64'(rd_hit_out), 64'((f_bm & mask) == mask));
      chk("rd_data", rd_data_out & expand(f_known), f_data & expand(f_known));
      chk("nf_rd_hit", 64'(rd_hit_nf), 64'((nf_bm & mask) == mask));
      chk("nf_rd_data", rd_data_nf & expand(nf_known), nf_data & expand(nf_known));
    end
  endtask

  function automatic logic [8:0] pick();
    if ($urandom_range(0, 3) == 0) return 9'h1F8 + 9'($urandom_range(0, 7));
    return 9'($urandom_range(0, 15));
  endfunction

  typedef struct {
    logic        wv;  logic [8:0] wa; logic [63:0] wd; logic [7:0] bv;
    logic        rr;  logic [8:0] ra; logic [7:0]  rm;
    logic        cv;  logic [8:0] ca;
    logic        ev;  logic       eh; logic        cd; logic [63:0] ed; logic [9:0] ec;
    logic        cn;  logic       enh;
  } vec_t;

  vec_t vecs [17];

  initial begin
    forever begin
      #400000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
    end
  end

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem_m[i] = '0; known_m[i] = '0; bm_m[i] = '0;
    end
    // Fields: wv wa wd bv | rr ra rm | cv ca | ev eh cd ed ec | cn enh
    vecs[0]  = '{0, 9'h000, 64'h0, 8'h00, 1, 9'h005, 8'hFF, 0, 9'h0, 1, 0, 0, 64'h0, 10'd0, 0, 0};
    vecs[1]  = '{1, 9'h010, 64'h1122334455667788, 8'h0F, 0, 9'h0, 8'h00, 0, 9'h0,
                 0, 0, 0, 64'h0, 10'd0, 0, 0};
    vecs[2]  = '{1, 9'h010, 64'hAABBCCDD00000000, 8'hF0, 0, 9'h0, 8'h00, 0, 9'h0,
                 0, 0, 0, 64'h0, 10'd1, 0, 0};
    vecs[3]  = '{0, 9'h0, 64'h0, 8'h00, 1, 9'h010, 8'hFF, 0, 9'h0,
                 1, 1, 1, 64'hAABBCCDD55667788, 10'd1, 0, 0};
    vecs[4]  = '{1, 9'h010, 64'h00000000000000EE, 8'h01, 0, 9'h0, 8'h00, 1, 9'h010,
                 0, 0, 0, 64'h0, 10'd0, 0, 0};
    vecs[5]  = '{0, 9'h0, 64'h0, 8'h00, 1, 9'h010, 8'h03, 0, 9'h0,
                 1, 0, 1, 64'hAABBCCDD556677EE, 10'd0, 0, 0};
    vecs[6]  = '{0, 9'h0, 64'h0, 8'h00, 1, 9'h010, 8'h01, 0, 9'h0,
                 1, 1, 1, 64'hAABBCCDD556677EE, 10'd0, 0, 0};
    vecs[7]  = '{1, 9'h020, 64'hDEADBEEFCAFEF00D, 8'hFF, 1, 9'h020, 8'hFF, 0, 9'h0,
                 1, 1, 1, 64'hDEADBEEFCAFEF00D, 10'd1, 1, 0};
    vecs[8]  = '{0, 9'h0, 64'h0, 8'h00, 1, 9'h020, 8'hFF, 0, 9'h0,
                 1, 1, 1, 64'hDEADBEEFCAFEF00D, 10'd1, 1, 1};
    vecs[9]  = '{1, 9'h1FF, 64'h0123456789ABCDEF, 8'hFF, 0, 9'h0, 8'h00, 0, 9'h0,
                 0, 0, 0, 64'h0, 10'd2, 0, 0};
    vecs[10] = '{1, 9'h000, 64'hFEDCBA9876543210, 8'hFF, 0, 9'h0, 8'h00, 0, 9'h0,
                 0, 0, 0, 64'h0, 10'd3, 0, 0};
    vecs[11] = '{0, 9'h0, 64'h0, 8'h00, 1, 9'h1FF, 8'hFF, 0, 9'h0,
                 1, 1, 1, 64'h0123456789ABCDEF, 10'd3, 0, 0};
    vecs[12] = '{0, 9'h0, 64'h0, 8'h00, 1, 9'h000, 8'hFF, 0, 9'h0,
                 1, 1, 1, 64'hFEDCBA9876543210, 10'd3, 0, 0};
    vecs[13] = '{1, 9'h030, 64'h5A5A5A5A5A5A5A5A, 8'hFF, 0, 9'h0, 8'h00, 1, 9'h020,
                 0, 0, 0, 64'h0, 10'd3, 0, 0};
    vecs[14] = '{0, 9'h0, 64'h0, 8'h00, 1, 9'h020, 8'hFF, 0, 9'h0,
                 1, 0, 1, 64'hDEADBEEFCAFEF00D, 10'd3, 0, 0};
    vecs[15] = '{0, 9'h0, 64'h0, 8'h00, 1, 9'h005, 8'h00, 0, 9'h0, 1, 1, 0, 64'h0, 10'd3, 0, 0};
    vecs[16] = '{0, 9'h0, 64'h0, 8'h00, 0, 9'h0, 8'h00, 0, 9'h0, 0, 0, 0, 64'h0, 10'd3, 0, 0};

    rst_n = 1'b0;
    wr_valid = 0; wr_address = '0; wr_data = '0; wr_byte_valid = '0;
    rd_req = 0; rd_address = '0; rd_byte_mask = '0; clr_valid = 0; clr_address = '0;
    #12;
    chk("reset_rd_valid", 64'(rd_valid_out), 64'h0);
    chk("reset_rd_hit", 64'(rd_hit_out), 64'h0);
    chk("reset_rd_data", rd_data_out, 64'h0);
    chk("reset_wr_count", 64'(wr_count_out), 64'h0);
    #11;
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      wr_valid = vecs[k].wv; wr_address = vecs[k].wa; wr_data = vecs[k].wd;
      wr_byte_valid = vecs[k].bv;
      rd_req = vecs[k].rr; rd_address = vecs[k].ra; rd_byte_mask = vecs[k].rm;
      clr_valid = vecs[k].cv; clr_address = vecs[k].ca;
      cycle();
      chk($sformatf("vec%0d_valid", k), 64'(rd_valid_out), 64'(vecs[k].ev));
      chk($sformatf("vec%0d_count", k), 64'(wr_count_out), 64'(vecs[k].ec));
      if (vecs[k].ev) chk($sformatf("vec%0d_hit", k), 64'(rd_hit_out), 64'(vecs[k].eh));
      if (vecs[k].cd) chk($sformatf("vec%0d_data", k), rd_data_out, vecs[k].ed);
      if (vecs[k].cn) chk($sformatf("vec%0d_nf_hit", k), 64'(rd_hit_nf), 64'(vecs[k].enh));
    end

    // Async reset between the request edge and the result edge.
    wr_valid = 0; clr_valid = 0;
    rd_req = 1; rd_address = 9'h000; rd_byte_mask = 8'hFF;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rd_valid", 64'(rd_valid_out), 64'h0);
    chk("midrst_rd_hit", 64'(rd_hit_out), 64'h0);
    chk("midrst_rd_data", rd_data_out, 64'h0);
    chk("midrst_wr_count", 64'(wr_count_out), 64'h0);
    for (int i = 0; i < 512; i++) bm_m[i] = '0;
    rd_req = 0;
    @(negedge clk);
    rst_n = 1'b1;
    rd_req = 1; rd_address = 9'h000; rd_byte_mask = 8'hFF;
    cycle();
    chk("postrst_hit", 64'(rd_hit_out), 64'h0);
    chk("postrst_data", rd_data_out, 64'hFEDCBA9876543210);

    // Randomized traffic concentrated on a few lines, including the wrap boundary.
    for (int n = 0; n < 3000; n++) begin
      wr_valid      = 1'($urandom_range(0, 1));
      wr_address    = pick();
      wr_data       = {$urandom(), $urandom()};
      wr_byte_valid = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom());
      rd_req        = ($urandom_range(0, 3) != 0);
      rd_address    = ($urandom_range(0, 2) == 0) ? wr_address : pick();
      rd_byte_mask  = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom());
      clr_valid     = ($urandom_range(0, 7) == 0);
      clr_address   = ($urandom_range(0, 1) == 0) ? rd_address : pick();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
